covuniq_stage: RTL and testbench
================================

# covuniq_stage

Parametrised successor to the `dut` chain stage, sitting on the `dut_if` cmd/adr/data path between an upstream (slave) and a downstream (master) stage. Each transaction is either consumed locally or forwarded:
- Consumed: its address equals the stage's own address. It updates hit statistics and a unique-data coverage bitmap.
- Forwarded: any other address. It passes through a DEPTH-entry FIFO with valid/ready back-pressure.

Chaining N instances with distinct MY_ADR values gives an address-routed pipeline with per-stage unique coverage.

## Interface
- DATA_W, 3, data width; the coverage bitmap has 2**DATA_W bits.
- ADR_W, 2, address width.
- MY_ADR, 1, address consumed by this stage.
- DEPTH, 4, forward FIFO entries; power of two, ≥2.
- CNT_W, 16, hit/forward counter width.
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_cmd  in  1  upstream transaction valid.
- s_adr  in  ADR_W  upstream address.
- s_data  in  DATA_W  upstream data.
- s_ready  out  1  stage can accept this cycle.
- m_cmd  out  1  downstream transaction valid.
- m_adr  out  ADR_W  downstream address.
- m_data  out  DATA_W  downstream data.
- m_ready  in  1  downstream accepts.
- clr  in  1  synchronous clear of statistics.
- hit_cnt  out  CNT_W  consumed transactions, saturating.
- fwd_cnt  out  CNT_W  forwarded (pushed) transactions, saturating.
- uniq_cnt  out  DATA_W+1  distinct data values consumed.
- all_seen  out  1  uniq_cnt == 2**DATA_W.

## Operation
- Accept: s_cmd && s_ready.
  - If s_adr == MY_ADR, the transaction is a hit. It does not enter the FIFO.
  - Otherwise it is forward and is pushed into the FIFO.
- s_ready = !full. Hits also stall when the FIFO is full, so stage ordering stays simple.
- FIFO:
  - Pop on m_cmd && m_ready.
  - m_cmd = !empty.
  - m_adr/m_data = head entry, driven from storage. No combinational path from s_* to m_*.
- On a hit:
  - hit_cnt increments.
  - If seen[s_data] == 0: set it and increment uniq_cnt.
  - A repeated value changes nothing except hit_cnt.
- On a forward push, fwd_cnt increments.
- Counters saturate at all-ones and never wrap. uniq_cnt cannot exceed 2**DATA_W by construction.
- clr:
  - Zeroes hit_cnt, fwd_cnt, uniq_cnt and seen[].
  - Does not touch FIFO contents or handshakes.
  - A hit or push in the same cycle as clr is still routed and transferred normally, but is not counted (clr wins).
- all_seen is combinational from uniq_cnt.

## Timing
- Reset (rst_n low, asynchronous):
  - FIFO emptied.
  - m_cmd=0, m_adr=0, m_data=0.
  - s_ready=1 once reset is released.
  - All counters and seen[] = 0; all_seen=0.
- Reset mid-operation discards all buffered transactions without emitting them.
- Forward latency: pushed at edge k → m_cmd=1 with that entry from after edge k (visible in cycle k+1).
- Throughput: 1 transaction per cycle with m_ready held high.
- Simultaneous push and pop:
  - Non-full: occupancy unchanged.
  - Empty: the pushed entry appears next cycle; there is no same-cycle bypass.
- Full: s_ready=0. A pop that cycle frees the slot and s_ready=1 next cycle. There is no same-cycle refill.
- Statistics update on the accepting edge and are visible the following cycle.
- Pointer wrap: log2(DEPTH)+1-bit read/write pointers. The MSB distinguishes full from empty.

## Structure
- Package covuniq_pkg holds:
  - the packed struct typedef for {cmd, adr, data}, parametrised by width via localparams;
  - the DATA_W/ADR_W defaults;
  - the `dut_if` channel types.
- Sub-module covuniq_fifo(DEPTH, W): synchronous FIFO with push/pop/full/empty, the same clk/rst_n, and registered storage.
- The top holds the routing compare, the counters and the seen[] bitmap.

## Test plan
- Reset, then idle -> s_ready=1, m_cmd=0, all counters 0, all_seen=0.
- Send adr=2 data=5 with m_ready=1 -> m_cmd=1 with adr=2 data=5 the next cycle; fwd_cnt=1, hit_cnt=0.
- Send adr=1 for data 0..7, with data=3 sent twice -> hit_cnt=9, uniq_cnt=8, all_seen=1, m_cmd never asserted.
- m_ready=0, push 4 forwards -> s_ready=0 after the 4th. Raise m_ready for 1 cycle -> one pop, s_ready=1 the next cycle, and entries come out in order.
- Assert clr in the same cycle as a hit on data=6 -> next cycle hit_cnt=0, uniq_cnt=0, seen[6]=0.
- Drop rst_n with 3 entries buffered -> m_cmd=0 immediately; after release the FIFO is empty and counters are 0.

Source files
------------

// File: rtl/covuniq_pkg.sv
// covuniq_pkg: shared types and defaults for the covuniq address-routed stage.
//   - DataWDefault / AdrWDefault : default channel widths
//   - chan_t                     : packed {cmd, adr, data} channel beat at default widths
//   - route_e / route_of()       : per-cycle routing decision of an accepted beat
package covuniq_pkg;

  localparam int unsigned DataWDefault = 3;
  localparam int unsigned AdrWDefault  = 2;
  localparam int unsigned ChanWDefault = 1 + AdrWDefault + DataWDefault;

  typedef struct packed {
    logic                    cmd;
    logic [AdrWDefault-1:0]  adr;
    logic [DataWDefault-1:0] data;
  } chan_t;

  typedef enum logic [1:0] {
    RouteNone,
    RouteHit,
    RouteFwd
  } route_e;

  // An accepted beat is a hit when its address matches, otherwise it is forwarded.
  function automatic route_e route_of(input logic accept, input logic adr_match);
    if (!accept) begin
      return RouteNone;
    end
    return adr_match ? RouteHit : RouteFwd;
  endfunction

endpackage

// File: rtl/covuniq_if.sv
// covuniq_if: cmd/adr/data channel with ready back-pressure.
//   master : drives cmd, adr, data; samples ready
//   slave  : samples cmd, adr, data; drives ready
interface covuniq_if #(
  parameter int unsigned ADR_W  = 2,
  parameter int unsigned DATA_W = 3
) ();

  logic              cmd;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output cmd, output adr, output data, input ready);
  modport slave  (input cmd, input adr, input data, output ready);

endinterface

// File: rtl/covuniq_fifo.sv
// covuniq_fifo: synchronous FIFO with registered storage.
//   clk, rst_n     : clock, asynchronous active-low reset (empties FIFO, zeroes storage)
//   push, wdata    : write request and data (ignored when full)
//   pop            : read request (ignored when empty)
//   rdata          : head entry, straight from storage
//   full, empty    : occupancy flags
module covuniq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/covuniq_stage.sv
// covuniq_stage: address-routed chain stage with per-stage unique-data coverage.
//   clk, rst_n : clock, asynchronous active-low reset
//   s          : upstream channel (slave); beats with adr == MY_ADR are consumed here
//   m          : downstream channel (master); all other beats via a DEPTH-entry FIFO
//   clr        : synchronous clear of hit_cnt, fwd_cnt, uniq_cnt and the seen bitmap
//   hit_cnt    : consumed beats, saturating
//   fwd_cnt    : forwarded beats, saturating
//   uniq_cnt   : distinct data values consumed
//   all_seen   : every data value has been consumed at least once
module covuniq_stage
  import covuniq_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADR_W  = AdrWDefault,
  parameter int unsigned MY_ADR = 1,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  covuniq_if.slave          s,
  covuniq_if.master         m,
  input  logic              clr,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [DATA_W:0]   uniq_cnt,
  output logic              all_seen
);

  localparam int unsigned      NVals  = 1 << DATA_W;
  localparam logic [ADR_W-1:0] MyAdr  = ADR_W'(MY_ADR);
  localparam logic [DATA_W:0]  NValsW = (DATA_W+1)'(NVals);

  logic              full, empty, push, pop;
  route_e            route;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic [DATA_W:0]   uniq_cnt_q, uniq_cnt_d;
  logic [NVals-1:0]  seen_q, seen_d;

  // Hits also wait on a full FIFO so every accept shares one ready.
  assign s.ready = !full;
  assign m.cmd   = !empty;
  assign pop     = !empty && m.ready;
  assign route   = route_of(s.cmd && !full, s.adr == MyAdr);
  assign push    = (route == RouteFwd);

  covuniq_fifo #(
    .DEPTH (DEPTH),
    .W     (ADR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({s.adr, s.data}),
    .pop   (pop),
    .rdata ({m.adr, m.data}),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    fwd_cnt_d  = fwd_cnt_q;
    uniq_cnt_d = uniq_cnt_q;
    seen_d     = seen_q;
    if (clr) begin
      // Transfers this cycle still route normally; they just go uncounted.
      hit_cnt_d  = '0;
      fwd_cnt_d  = '0;
      uniq_cnt_d = '0;
      seen_d     = '0;
    end else begin
      if (route == RouteHit) begin
        if (hit_cnt_q != '1) begin
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if (!seen_q[s.data]) begin
          seen_d[s.data] = 1'b1;
          uniq_cnt_d     = uniq_cnt_q + (DATA_W+1)'(1);
        end
      end
      if (route == RouteFwd && fwd_cnt_q != '1) begin
        fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      fwd_cnt_q  <= '0;
      uniq_cnt_q <= '0;
      seen_q     <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      fwd_cnt_q  <= fwd_cnt_d;
      uniq_cnt_q <= uniq_cnt_d;
      seen_q     <= seen_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign fwd_cnt  = fwd_cnt_q;
  assign uniq_cnt = uniq_cnt_q;
  assign all_seen = (uniq_cnt_q == NValsW);

endmodule

// File: tb/tb_covuniq_stage.sv
module tb_covuniq_stage;
  import covuniq_pkg::*;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned ADR_W  = 2;
  localparam int unsigned MY_ADR = 1;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic [CNT_W-1:0]  hit_cnt, fwd_cnt;
  logic [DATA_W:0]   uniq_cnt;
  logic              all_seen;

  covuniq_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) s_if ();
  covuniq_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) m_if ();

  covuniq_stage #(
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W),
    .MY_ADR (MY_ADR),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s_if),
    .m        (m_if),
    .clr      (clr),
    .hit_cnt  (hit_cnt),
    .fwd_cnt  (fwd_cnt),
    .uniq_cnt (uniq_cnt),
    .all_seen (all_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned mcmd_cnt = 0;
  chan_t       sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: expected beats queued on accepted forwards, compared on each downstream pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.cmd) mcmd_cnt++;
      if (m_if.cmd && m_if.ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pop", 32'(1), 32'(0));
        end else begin
          chan_t e;
          e = sb_q.pop_front();
          check("sb_adr", 32'(m_if.adr), 32'(e.adr));
          check("sb_data", 32'(m_if.data), 32'(e.data));
        end
      end
      if (s_if.cmd && s_if.ready && clr !== 1'bx && 32'(s_if.adr) != MY_ADR) begin
        chan_t n;
        n.cmd  = 1'b1;
        n.adr  = s_if.adr;
        n.data = s_if.data;
        sb_q.push_back(n);
      end
    end
  end

  // All stimulus tasks enter and leave 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic ok;
    ok        = 1'b0;
    s_if.cmd  = 1'b1;
    s_if.adr  = a;
    s_if.data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = s_if.ready;
      next_cycle();
      if (ok) break;
    end
    if (!ok) check("send_timeout", 32'(0), 32'(1));
    s_if.cmd = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!m_if.cmd) break;
    end
    check("drain_m_cmd", 32'(m_if.cmd), 32'(0));
    next_cycle();
  endtask

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b0;
    s_if.cmd   = 1'b0;
    s_if.adr   = '0;
    s_if.data  = '0;
    m_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset / idle state
    @(negedge clk);
    check("rst_s_ready", 32'(s_if.ready), 32'(1));
    check("rst_m_cmd", 32'(m_if.cmd), 32'(0));
    check("rst_m_adr", 32'(m_if.adr), 32'(0));
    check("rst_m_data", 32'(m_if.data), 32'(0));
    check("rst_hit", 32'(hit_cnt), 32'(0));
    check("rst_fwd", 32'(fwd_cnt), 32'(0));
    check("rst_uniq", 32'(uniq_cnt), 32'(0));
    check("rst_all_seen", 32'(all_seen), 32'(0));
    next_cycle();

    // Single forward, visible the cycle after acceptance
    m_if.ready = 1'b1;
    send(2'd2, 3'd5);
    @(negedge clk);
    check("fwd_m_cmd", 32'(m_if.cmd), 32'(1));
    check("fwd_m_adr", 32'(m_if.adr), 32'(2));
    check("fwd_m_data", 32'(m_if.data), 32'(5));
    check("fwd_fwd_cnt", 32'(fwd_cnt), 32'(1));
    check("fwd_hit_cnt", 32'(hit_cnt), 32'(0));
    next_cycle();

    // Hits covering every data value, 3 twice
    mcmd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'd1, 3'(i));
      if (i == 3) send(2'd1, 3'd3);
    end
    @(negedge clk);
    check("hit_hit_cnt", 32'(hit_cnt), 32'(9));
    check("hit_uniq_cnt", 32'(uniq_cnt), 32'(8));
    check("hit_all_seen", 32'(all_seen), 32'(1));
    check("hit_fwd_cnt", 32'(fwd_cnt), 32'(1));
    check("hit_no_m_cmd", 32'(mcmd_cnt), 32'(0));
    next_cycle();

    // Fill FIFO with downstream stalled
    m_if.ready = 1'b0;
    send(2'd0, 3'd1);
    send(2'd2, 3'd2);
    send(2'd3, 3'd3);
    send(2'd0, 3'd4);
    @(negedge clk);
    check("full_s_ready", 32'(s_if.ready), 32'(0));
    check("full_m_cmd", 32'(m_if.cmd), 32'(1));
    check("full_fwd_cnt", 32'(fwd_cnt), 32'(5));
    next_cycle();
    // One pop: the slot frees only after the edge
    m_if.ready = 1'b1;
    @(negedge clk);
    check("pop_same_cycle_ready", 32'(s_if.ready), 32'(0));
    next_cycle();
    m_if.ready = 1'b0;
    @(negedge clk);
    check("pop_next_ready", 32'(s_if.ready), 32'(1));
    next_cycle();
    m_if.ready = 1'b1;
    drain();
    check("full_sb_empty", 32'(sb_q.size()), 32'(0));

    // clr wins over a same-cycle hit
    s_if.cmd  = 1'b1;
    s_if.adr  = 2'd1;
    s_if.data = 3'd6;
    clr       = 1'b1;
    next_cycle();
    s_if.cmd = 1'b0;
    clr      = 1'b0;
    @(negedge clk);
    check("clr_hit_cnt", 32'(hit_cnt), 32'(0));
    check("clr_uniq_cnt", 32'(uniq_cnt), 32'(0));
    check("clr_fwd_cnt", 32'(fwd_cnt), 32'(0));
    check("clr_all_seen", 32'(all_seen), 32'(0));
    next_cycle();
    send(2'd1, 3'd6);
    send(2'd1, 3'd6);
    @(negedge clk);
    check("clr_seen6_cleared", 32'(uniq_cnt), 32'(1));
    check("clr_repeat_hit", 32'(hit_cnt), 32'(2));
    next_cycle();

    // Reset with buffered entries
    m_if.ready = 1'b0;
    send(2'd0, 3'd7);
    send(2'd2, 3'd1);
    send(2'd3, 3'd2);
    @(negedge clk);
    check("pre_rst_fwd_cnt", 32'(fwd_cnt), 32'(3));
    check("pre_rst_m_cmd", 32'(m_if.cmd), 32'(1));
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("async_rst_m_cmd", 32'(m_if.cmd), 32'(0));
    check("async_rst_m_adr", 32'(m_if.adr), 32'(0));
    check("async_rst_m_data", 32'(m_if.data), 32'(0));
    sb_q.delete();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_if.ready), 32'(1));
    check("post_rst_m_cmd", 32'(m_if.cmd), 32'(0));
    check("post_rst_hit", 32'(hit_cnt), 32'(0));
    check("post_rst_fwd", 32'(fwd_cnt), 32'(0));
    check("post_rst_uniq", 32'(uniq_cnt), 32'(0));
    next_cycle();
    m_if.ready = 1'b1;
    send(2'd2, 3'd3);
    drain();
    check("post_rst_sb_empty", 32'(sb_q.size()), 32'(0));
    check("post_rst_fwd_one", 32'(fwd_cnt), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
